// File: rtl/matmul_sequencer_pkg.sv
// Shared types and constants for the matmul instruction sequencer:
// instruction layout, opcodes, FSM states and error codes.
package tpu_seq_pkg;

   localparam int OPCODE_W   = 3;
   localparam int ADDR_W     = 13;
   localparam int INSTR_W    = 16;
   localparam int OPCODE_LSB = ADDR_W;

   typedef enum logic [OPCODE_W-1:0] {
      OP_NOP         = 3'b000,
      OP_LOAD_WEIGHT = 3'b001,
      OP_LOAD_INPUT  = 3'b010,
      OP_MATMUL      = 3'b011,
      OP_STORE       = 3'b100,
      OP_HALT        = 3'b111
   } opcode_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MATMUL,
      S_WAIT_ACC,
      S_STORE,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_PC_OVF  = 2'b11;

   function automatic logic [OPCODE_W-1:0] instr_opcode(input logic [INSTR_W-1:0] instr);
      return instr[OPCODE_LSB +: OPCODE_W];
   endfunction

   function automatic logic [ADDR_W-1:0] instr_address(input logic [INSTR_W-1:0] instr);
      return instr[ADDR_W-1:0];
   endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// Sequencer-side bundle: program ROM port, datapath strobes, accumulator
// status and run status. master = sequencer, slave = surrounding system.
interface matmul_sequencer_if
   import tpu_seq_pkg::*;
#(
   parameter int PC_W = 8
);
   logic                start;
   logic [PC_W-1:0]     instr_addr;
   logic [INSTR_W-1:0]  instr_data;
   logic                acc1_full;
   logic                acc2_full;
   logic                load_weight;
   logic                load_input;
   logic                valid;
   logic                store;
   logic [ADDR_W-1:0]   base_address;
   logic                busy;
   logic                done;
   logic                error;
   logic [1:0]          err_code;

   modport master (
      input  start, instr_data, acc1_full, acc2_full,
      output instr_addr, load_weight, load_input, valid, store,
             base_address, busy, done, error, err_code
   );

   modport slave (
      output start, instr_data, acc1_full, acc2_full,
      input  instr_addr, load_weight, load_input, valid, store,
             base_address, busy, done, error, err_code
   );
endinterface

// File: rtl/matmul_sequencer_counter.sv
// Loadable down-counter with zero flag; one instance serves both the MATMUL
// length and the accumulator-wait timeout since those phases never overlap.
module seq_cycle_counter #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         dec,
   output logic         zero
);
   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);
endmodule

// File: rtl/matmul_sequencer.sv
// Instruction-driven sequencer for the 2x2 systolic matmul datapath.
//
// state      | meaning
// S_IDLE     | after reset, waiting for start
// S_FETCH    | instr_addr = pc presented to ROM
// S_DECODE   | ROM data valid, opcode decoded, address field latched
// S_EXEC     | one-cycle load strobe (or nothing for NOP)
// S_MATMUL   | valid held for MATMUL_CYCLES cycles
// S_WAIT_ACC | waiting for both accumulators full, with timeout
// S_STORE    | one-cycle store strobe
// S_DONE     | HALT reached, done held until next start
// S_ERROR    | fault, error/err_code held until next start
module matmul_sequencer
   import tpu_seq_pkg::*;
#(
   parameter int PC_W          = 8,
   parameter int MATMUL_CYCLES = 5,
   parameter int ACC_TIMEOUT   = 16
) (
   input  logic                clk,
   input  logic                reset,
   matmul_sequencer_if.master  bus
);
   localparam int CNT_MAX = (MATMUL_CYCLES > ACC_TIMEOUT) ? MATMUL_CYCLES : ACC_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [PC_W-1:0]  PC_LAST = '1;
   localparam logic [CNT_W-1:0] MM_LOAD = CNT_W'(MATMUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(ACC_TIMEOUT - 1);

   state_t               state, state_next;
   logic [PC_W-1:0]      pc;
   logic [ADDR_W-1:0]    ir_addr;
   logic [OPCODE_W-1:0]  dec_op;
   logic [ADDR_W-1:0]    dec_addr;
   logic                 start_ok, finish, pc_inc, err_set;
   logic [1:0]           err_val;
   logic                 cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0]     cnt_value;

   assign dec_op   = instr_opcode(bus.instr_data);
   assign dec_addr = instr_address(bus.instr_data);

   seq_cycle_counter #(.W(CNT_W)) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .load       (cnt_load),
      .load_value (cnt_value),
      .dec        (cnt_dec),
      .zero       (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      start_ok   = 1'b0;
      finish     = 1'b0;
      pc_inc     = 1'b0;
      err_set    = 1'b0;
      err_val    = ERR_NONE;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      cnt_value  = '0;
      unique case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (bus.start) begin
               state_next = S_FETCH;
               start_ok   = 1'b1;
            end
         end
         S_FETCH: state_next = S_DECODE;
         S_DECODE: begin
            case (dec_op)
               OP_HALT: state_next = S_DONE;
               OP_MATMUL: begin
                  state_next = S_MATMUL;
                  cnt_load   = 1'b1;
                  cnt_value  = MM_LOAD;
               end
               OP_STORE: begin
                  state_next = S_WAIT_ACC;
                  cnt_load   = 1'b1;
                  cnt_value  = TO_LOAD;
               end
               OP_NOP, OP_LOAD_WEIGHT, OP_LOAD_INPUT: state_next = S_EXEC;
               default: begin
                  state_next = S_ERROR;
                  err_set    = 1'b1;
                  err_val    = ERR_ILLEGAL;
               end
            endcase
         end
         S_EXEC: finish = 1'b1;
         S_MATMUL: begin
            if (cnt_zero) finish  = 1'b1;
            else          cnt_dec = 1'b1;
         end
         S_WAIT_ACC: begin
            if (bus.acc1_full && bus.acc2_full) begin
               state_next = S_STORE;
            end else if (cnt_zero) begin
               state_next = S_ERROR;
               err_set    = 1'b1;
               err_val    = ERR_TIMEOUT;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         S_STORE: finish = 1'b1;
         default: state_next = S_IDLE;
      endcase
      // The last ROM slot may not complete unless it is HALT: no wrap to 0.
      if (finish) begin
         if (pc == PC_LAST) begin
            state_next = S_ERROR;
            err_set    = 1'b1;
            err_val    = ERR_PC_OVF;
         end else begin
            state_next = S_FETCH;
            pc_inc     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc               <= '0;
         ir_addr          <= '0;
         bus.load_weight  <= 1'b0;
         bus.load_input   <= 1'b0;
         bus.valid        <= 1'b0;
         bus.store        <= 1'b0;
         bus.base_address <= '0;
         bus.busy         <= 1'b0;
         bus.done         <= 1'b0;
         bus.error        <= 1'b0;
         bus.err_code     <= ERR_NONE;
      end else begin
         bus.load_weight <= (state_next == S_EXEC) && (dec_op == OP_LOAD_WEIGHT);
         bus.load_input  <= (state_next == S_EXEC) && (dec_op == OP_LOAD_INPUT);
         bus.valid       <= (state_next == S_MATMUL);
         bus.store       <= (state_next == S_STORE);
         bus.busy        <= !(state_next inside {S_IDLE, S_DONE, S_ERROR});
         bus.done        <= (state_next == S_DONE);
         bus.error       <= (state_next == S_ERROR);
         if (state == S_DECODE) ir_addr <= dec_addr;
         if ((state_next == S_EXEC) &&
             ((dec_op == OP_LOAD_WEIGHT) || (dec_op == OP_LOAD_INPUT))) begin
            bus.base_address <= dec_addr;
         end else if (state_next == S_STORE) begin
            bus.base_address <= ir_addr;
         end
         if (start_ok) begin
            pc           <= '0;
            bus.err_code <= ERR_NONE;
         end else if (pc_inc) begin
            pc <= pc + 1'b1;
         end
         if (err_set) bus.err_code <= err_val;
      end
   end

   assign bus.instr_addr = pc;
endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: a timeline model derived from per-opcode cycle
// costs is compared every cycle, plus literal checks on key events.
`timescale 1ns/1ps
module tb_matmul_sequencer;
   import tpu_seq_pkg::*;

   localparam int N = 64;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   matmul_sequencer_if #(.PC_W(8)) bus();
   matmul_sequencer_if #(.PC_W(2)) bus2();

   matmul_sequencer #(.PC_W(8), .MATMUL_CYCLES(5), .ACC_TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .bus(bus));
   matmul_sequencer #(.PC_W(2), .MATMUL_CYCLES(5), .ACC_TIMEOUT(16)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2));

   logic [15:0] rom [0:255];
   always @(posedge clk) bus.instr_data <= rom[bus.instr_addr];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int base_cyc = 0;
   logic chk_en = 1'b0;
   always @(posedge clk) cyc <= cyc + 1;

   // expected timeline, index = cycles after the accepted start edge
   logic [7:0]  e_ia   [N];
   logic [12:0] e_base [N];
   logic        e_lw [N], e_li [N], e_val [N], e_st [N];
   logic        e_busy [N], e_done [N], e_err [N];
   logic [1:0]  e_code [N];
   logic [12:0] last_base;
   int          acc_c;

   int obs_val, obs_lw, obs_li, obs_st, obs_err_t;
   logic [12:0] obs_lw_addr, obs_li_addr, obs_st_addr;

   function automatic logic [15:0] enc(input logic [2:0] op, input logic [12:0] a);
      return {op, a};
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic put(input int t, input int pc, input logic [12:0] b);
      if (t < N) begin
         e_ia[t] = pc[7:0]; e_base[t] = b; e_busy[t] = 1'b1;
      end
   endtask

   task automatic build(input int rst_t);
      int t, pc, fin, w, c;
      logic [12:0] b, ad;
      logic [2:0] op;
      logic dn, er, completed;
      logic [1:0] code;
      t = 0; pc = 0; fin = -1; b = last_base; dn = 0; er = 0; code = 2'd0; acc_c = 1000;
      for (int i = 0; i < N; i++) begin
         e_ia[i] = 0; e_base[i] = 0; e_lw[i] = 0; e_li[i] = 0; e_val[i] = 0; e_st[i] = 0;
         e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0; e_code[i] = 0;
      end
      while (fin < 0 && t < N - 30) begin
         op = rom[pc][15:13]; ad = rom[pc][12:0]; completed = 0;
         put(t, pc, b); put(t + 1, pc, b);
         if (op == 3'd0 || op == 3'd1 || op == 3'd2) begin
            if (op != 3'd0) b = ad;
            put(t + 2, pc, b);
            e_lw[t + 2] = (op == 3'd1);
            e_li[t + 2] = (op == 3'd2);
            t += 3; completed = 1;
         end else if (op == 3'd3) begin
            for (int i = 2; i < 7; i++) begin put(t + i, pc, b); e_val[t + i] = 1; end
            acc_c = t + 9;   // full two cycles after valid drops
            t += 7; completed = 1;
         end else if (op == 3'd4) begin
            w = t + 2; c = (acc_c > w) ? acc_c : w;
            if (c - w >= 16) begin
               for (int i = w; i < w + 16; i++) put(i, pc, b);
               er = 1; code = 2'd2; fin = w + 16;
            end else begin
               for (int i = w; i <= c; i++) put(i, pc, b);
               b = ad; put(c + 1, pc, b); e_st[c + 1] = 1;
               t = c + 2; completed = 1;
            end
         end else if (op == 3'd7) begin
            dn = 1; fin = t + 2;
         end else begin
            er = 1; code = 2'd1; fin = t + 2;
         end
         if (completed) begin
            if (pc == 255) begin er = 1; code = 2'd3; fin = t; end
            else pc++;
         end
      end
      if (fin < 0) fin = t;
      for (int i = fin; i < N; i++) begin
         e_ia[i] = pc[7:0]; e_base[i] = b; e_busy[i] = 0;
         e_done[i] = dn; e_err[i] = er; e_code[i] = code;
      end
      last_base = b;
      if (rst_t >= 0) begin
         for (int i = rst_t + 1; i < N; i++) begin
            e_ia[i] = 0; e_base[i] = 0; e_lw[i] = 0; e_li[i] = 0; e_val[i] = 0; e_st[i] = 0;
            e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0; e_code[i] = 0;
         end
         last_base = 0;
      end
   endtask

   always @(posedge clk) begin
      #2;
      if (chk_en) begin : cmp
         int t;
         logic [29:0] got, exp;
         t = cyc - base_cyc;
         if (t >= 0 && t < N) begin
            got = {bus.instr_addr, bus.base_address, bus.load_weight, bus.load_input,
                   bus.valid, bus.store, bus.busy, bus.done, bus.error, bus.err_code};
            exp = {e_ia[t], e_base[t], e_lw[t], e_li[t], e_val[t], e_st[t],
                   e_busy[t], e_done[t], e_err[t], e_code[t]};
            checks++;
            if (got !== exp) begin
               failures++;
               $display("FAIL cycle t=%0d got ia=%0h base=%0h lw/li/v/st=%b%b%b%b busy=%b done=%b err=%b code=%0d expected ia=%0h base=%0h lw/li/v/st=%b%b%b%b busy=%b done=%b err=%b code=%0d",
                        t, bus.instr_addr, bus.base_address, bus.load_weight, bus.load_input,
                        bus.valid, bus.store, bus.busy, bus.done, bus.error, bus.err_code,
                        e_ia[t], e_base[t], e_lw[t], e_li[t], e_val[t], e_st[t],
                        e_busy[t], e_done[t], e_err[t], e_code[t]);
            end
            if (bus.valid) obs_val++;
            if (bus.load_weight) begin obs_lw++; obs_lw_addr = bus.base_address; end
            if (bus.load_input) begin obs_li++; obs_li_addr = bus.base_address; end
            if (bus.store) begin obs_st++; obs_st_addr = bus.base_address; end
            if (bus.error && obs_err_t < 0) obs_err_t = t;
         end
      end
   end

   task automatic run_prog(input int ncyc, input int rst_t, input int pulse_t, input logic acc1_hold);
      obs_val = 0; obs_lw = 0; obs_li = 0; obs_st = 0; obs_err_t = -1;
      obs_lw_addr = 0; obs_li_addr = 0; obs_st_addr = 0;
      @(negedge clk);
      bus.start = 1'b1; base_cyc = cyc + 1; chk_en = 1'b1;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         bus.start = (k == pulse_t);
         reset = !(k == rst_t);
         bus.acc1_full = acc1_hold || (k >= acc_c);
         bus.acc2_full = (k >= acc_c);
      end
      chk_en = 1'b0;
      bus.acc1_full = 1'b0; bus.acc2_full = 1'b0; reset = 1'b1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
   endtask

   task automatic load_main();
      clear_rom();
      rom[0] = enc(3'b001, 13'h0010);
      rom[1] = enc(3'b010, 13'h0020);
      rom[2] = enc(3'b011, 13'h0000);
      rom[3] = enc(3'b100, 13'h0030);
      rom[4] = enc(3'b111, 13'h0000);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int sum_v;
      logic zero_seen;
      logic e11, e12;
      logic [1:0] code12;
      bus.start = 0; bus.acc1_full = 0; bus.acc2_full = 0;
      bus2.start = 0; bus2.instr_data = 16'h0000; bus2.acc1_full = 0; bus2.acc2_full = 0;
      last_base = 0; acc_c = 1000;
      clear_rom();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done_err", {bus.done, bus.error}, 0);
      chk("rst_code", bus.err_code, 0);
      chk("rst_addr", bus.instr_addr, 0);
      chk("rst_base", bus.base_address, 0);
      chk("rst_strobes", {bus.load_weight, bus.load_input, bus.valid, bus.store}, 0);
      reset = 1'b1;
      @(negedge clk);

      // main program
      load_main();
      build(-1);
      sum_v = 0;
      for (int i = 0; i < N; i++) sum_v += e_val[i];
      chk("model_valid_count", sum_v, 5);
      chk("model_store_t16", e_st[16], 1);
      chk("model_done_t19", {e_done[18], e_done[19]}, 1);
      run_prog(26, -1, -1, 1'b0);
      chk("main_valid_cycles", obs_val, 5);
      chk("main_lw_count", obs_lw, 1);
      chk("main_lw_addr", obs_lw_addr, 'h10);
      chk("main_li_count", obs_li, 1);
      chk("main_li_addr", obs_li_addr, 'h20);
      chk("main_store_count", obs_st, 1);
      chk("main_store_addr", obs_st_addr, 'h30);
      chk("main_done_busy", {bus.done, bus.busy}, 2'b10);

      // restart from DONE with a stray start during MATMUL
      build(-1);
      run_prog(26, -1, 9, 1'b0);
      chk("pulse_valid_cycles", obs_val, 5);
      chk("pulse_done", bus.done, 1);

      // illegal opcode at pc 3
      clear_rom();
      rom[2] = enc(3'b001, 13'h0005);
      rom[3] = enc(3'b101, 13'h0000);
      build(-1);
      run_prog(16, -1, -1, 1'b0);
      chk("illegal_err_t", obs_err_t, 11);
      chk("illegal_code", bus.err_code, 1);
      chk("illegal_addr", bus.instr_addr, 3);
      chk("illegal_strobes", obs_val + obs_li + obs_st, 0);

      // accumulator timeout, acc2 never full
      clear_rom();
      rom[0] = enc(3'b001, 13'h0100);
      rom[1] = enc(3'b100, 13'h0200);
      build(-1);
      run_prog(26, -1, -1, 1'b1);
      chk("timeout_err_t", obs_err_t, 21);
      chk("timeout_code", bus.err_code, 2);
      chk("timeout_store", obs_st, 0);
      chk("timeout_base", bus.base_address, 'h100);

      // reset in the 3rd valid cycle, then rerun
      load_main();
      build(10);
      run_prog(20, 10, -1, 1'b0);
      chk("reset_valid_cycles", obs_val, 3);
      chk("reset_idle", {bus.busy, bus.instr_addr}, 0);
      build(-1);
      run_prog(26, -1, -1, 1'b0);
      chk("rerun_valid_cycles", obs_val, 5);
      chk("rerun_store_addr", obs_st_addr, 'h30);
      chk("rerun_done", bus.done, 1);

      // PC_W=2 instance: four NOPs overflow the program counter
      zero_seen = 0; e11 = 1'bx; e12 = 1'bx; code12 = 2'bxx;
      @(negedge clk);
      bus2.start = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         bus2.start = 1'b0;
         if (k >= 3 && bus2.instr_addr == 2'd0) zero_seen = 1;
         if (k == 11) e11 = bus2.error;
         if (k == 12) begin e12 = bus2.error; code12 = bus2.err_code; end
      end
      chk("ovf_err_before", e11, 0);
      chk("ovf_err_t12", e12, 1);
      chk("ovf_code", code12, 3);
      chk("ovf_no_wrap", zero_seen, 0);
      chk("ovf_addr", bus2.instr_addr, 3);
      chk("ovf_busy", bus2.busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
